// File: rtl/control_unit.sv
// Instruction decoder for the single-cycle MIPS core: combinational field split and
// control decode, with a one-flop reset stage that suppresses side-effect flags.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic        reg_write,
  output logic [1:0]  alu_src,
  output logic [2:0]  alu_op,
  output logic [4:0]  addr_a,
  output logic [4:0]  addr_b,
  output logic [4:0]  addr_in,
  output logic [4:0]  shamt,
  output logic [15:0] imm16,
  output logic [25:0] addr26,
  output logic        is_jump,
  output logic        is_branch
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  localparam logic [1:0] ALU_SRC_REG        = 2'd0;
  localparam logic [1:0] ALU_SRC_SEXT_IMM16 = 2'd1;
  localparam logic [1:0] ALU_SRC_ZEXT_IMM16 = 2'd2;
  localparam logic [1:0] ALU_SRC_SHAMT      = 2'd3;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] sh;
  logic [5:0] fn;

  assign op = instruction[31:26];
  assign rs = instruction[25:21];
  assign rt = instruction[20:16];
  assign rd = instruction[15:11];
  assign sh = instruction[10:6];
  assign fn = instruction[5:0];

  assign imm16  = instruction[15:0];
  assign addr26 = instruction[25:0];

  logic rst_q;
  logic reg_write_dec;
  logic is_jump_dec;
  logic is_branch_dec;

  always_ff @(posedge clk) begin
    rst_q <= reset;
  end

  always_comb begin
    addr_a        = rs;
    addr_b        = rt;
    addr_in       = rt;
    shamt         = 5'd0;
    alu_src       = ALU_SRC_REG;
    alu_op        = OP_ADD;
    reg_write_dec = 1'b0;
    is_jump_dec   = 1'b0;
    is_branch_dec = 1'b0;

    case (op)
      6'h00: begin
        addr_in       = rd;
        reg_write_dec = 1'b1;
        case (fn)
          6'h20: alu_op = OP_ADD;
          6'h22: alu_op = OP_SUB;
          6'h24: alu_op = OP_AND;
          6'h25: alu_op = OP_OR;
          6'h27: alu_op = OP_NOR;
          6'h2A: alu_op = OP_SLT;
          6'h00, 6'h02: begin
            // Shifts operate on rt; the amount comes from the instruction, not a register.
            addr_a  = rt;
            shamt   = sh;
            alu_src = ALU_SRC_SHAMT;
            alu_op  = (fn == 6'h00) ? OP_SLL : OP_SRL;
          end
          6'h08: begin
            is_jump_dec   = 1'b1;
            reg_write_dec = 1'b0;
          end
          default: reg_write_dec = 1'b0;
        endcase
      end
      6'h08: begin
        reg_write_dec = 1'b1;
        alu_src       = ALU_SRC_SEXT_IMM16;
      end
      6'h0A: begin
        reg_write_dec = 1'b1;
        alu_op        = OP_SLT;
        alu_src       = ALU_SRC_SEXT_IMM16;
      end
      6'h0C: begin
        reg_write_dec = 1'b1;
        alu_op        = OP_AND;
        alu_src       = ALU_SRC_ZEXT_IMM16;
      end
      6'h0D: begin
        reg_write_dec = 1'b1;
        alu_op        = OP_OR;
        alu_src       = ALU_SRC_ZEXT_IMM16;
      end
      6'h04, 6'h05: begin
        is_branch_dec = 1'b1;
        alu_op        = OP_SUB;
      end
      6'h02: is_jump_dec = 1'b1;
      default: ;
    endcase
  end

  // Only the side-effect flags are gated; data-path selects keep following the decode.
  assign reg_write = reg_write_dec & ~rst_q;
  assign is_jump   = is_jump_dec & ~rst_q;
  assign is_branch = is_branch_dec & ~rst_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: decode of each instruction class plus
// the reset stage gating reg_write/is_jump/is_branch.
module tb_control_unit;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  localparam logic [1:0] SRC_REG   = 2'd0;
  localparam logic [1:0] SRC_SEXT  = 2'd1;
  localparam logic [1:0] SRC_ZEXT  = 2'd2;
  localparam logic [1:0] SRC_SHAMT = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        reg_write;
  logic [1:0]  alu_src;
  logic [2:0]  alu_op;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [4:0]  addr_in;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic        is_jump;
  logic        is_branch;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .addr_in     (addr_in),
    .shamt       (shamt),
    .imm16       (imm16),
    .addr26      (addr26),
    .is_jump     (is_jump),
    .is_branch   (is_branch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one instruction (rst_q already low) and compare every decoded output.
  task automatic run_vec(input string name, input logic [31:0] ins,
                         input logic [4:0] ea, input logic [4:0] eb, input logic [4:0] ein,
                         input logic [4:0] esh, input logic [2:0] eop, input logic [1:0] esrc,
                         input logic erw, input logic ej, input logic ebr);
    instruction = ins;
    #1;
    check({name, ".addr_a"},    32'(addr_a),    32'(ea));
    check({name, ".addr_b"},    32'(addr_b),    32'(eb));
    check({name, ".addr_in"},   32'(addr_in),   32'(ein));
    check({name, ".shamt"},     32'(shamt),     32'(esh));
    check({name, ".alu_op"},    32'(alu_op),    32'(eop));
    check({name, ".alu_src"},   32'(alu_src),   32'(esrc));
    check({name, ".reg_write"}, 32'(reg_write), 32'(erw));
    check({name, ".is_jump"},   32'(is_jump),   32'(ej));
    check({name, ".is_branch"}, 32'(is_branch), 32'(ebr));
    check({name, ".imm16"},     32'(imm16),     {16'h0, ins[15:0]});
    check({name, ".addr26"},    32'(addr26),    {6'h0, ins[25:0]});
    $display("vec %-6s ins=%08h a=%0d b=%0d in=%0d sh=%0d op=%0d src=%0d rw=%0b j=%0b br=%0b",
             name, ins, addr_a, addr_b, addr_in, shamt, alu_op, alu_src, reg_write, is_jump, is_branch);
  endtask

  initial begin
    reset       = 1'b1;
    instruction = 32'h0800_0004;  // j 4
    @(posedge clk); #1;
    check("rst.is_jump",   32'(is_jump),   32'd0);
    check("rst.reg_write", 32'(reg_write), 32'd0);
    check("rst.addr26",    32'(addr26),    32'd4);
    $display("reset held: j applied, is_jump=%0b reg_write=%0b", is_jump, reg_write);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_pre_edge.is_jump", 32'(is_jump), 32'd0);
    @(posedge clk); #1;
    check("rst_release.is_jump", 32'(is_jump), 32'd1);
    $display("reset released: is_jump=%0b", is_jump);

    @(negedge clk);
    //      name     instr          a   b   in  sh  op      src        rw j  br
    run_vec("addi",  32'h2010FEFE,  0, 16, 16,  0, OP_ADD, SRC_SEXT,  1, 0, 0);
    run_vec("sll",   32'h00108400, 16, 16, 16, 16, OP_SLL, SRC_SHAMT, 1, 0, 0);
    run_vec("srl",   32'h00104042, 16, 16,  8,  1, OP_SRL, SRC_SHAMT, 1, 0, 0);
    run_vec("add",   32'h02114020, 16, 17,  8,  0, OP_ADD, SRC_REG,   1, 0, 0);
    run_vec("sub",   32'h02114022, 16, 17,  8,  0, OP_SUB, SRC_REG,   1, 0, 0);
    run_vec("and",   32'h02114024, 16, 17,  8,  0, OP_AND, SRC_REG,   1, 0, 0);
    run_vec("or",    32'h02114025, 16, 17,  8,  0, OP_OR,  SRC_REG,   1, 0, 0);
    run_vec("nor",   32'h02114027, 16, 17,  8,  0, OP_NOR, SRC_REG,   1, 0, 0);
    run_vec("slt",   32'h0211402A, 16, 17,  8,  0, OP_SLT, SRC_REG,   1, 0, 0);
    run_vec("badfn", 32'h02114021, 16, 17,  8,  0, OP_ADD, SRC_REG,   0, 0, 0);
    run_vec("jr",    32'h03E00008, 31,  0,  0,  0, OP_ADD, SRC_REG,   0, 1, 0);
    run_vec("slti",  32'h2A08FFFF, 16,  8,  8,  0, OP_SLT, SRC_SEXT,  1, 0, 0);
    run_vec("andi",  32'h320900CF, 16,  9,  9,  0, OP_AND, SRC_ZEXT,  1, 0, 0);
    run_vec("ori",   32'h360900C0, 16,  9,  9,  0, OP_OR,  SRC_ZEXT,  1, 0, 0);
    run_vec("j",     32'h08000004,  0,  0,  0,  0, OP_ADD, SRC_REG,   0, 1, 0);
    run_vec("bne",   32'h1520FFFD,  9,  0,  0,  0, OP_SUB, SRC_REG,   0, 0, 1);
    run_vec("beq",   32'h11090003,  8,  9,  9,  0, OP_SUB, SRC_REG,   0, 0, 1);
    run_vec("unk",   32'hFC4307C5,  2,  3,  3,  0, OP_ADD, SRC_REG,   0, 0, 0);

    // Reset raised mid-stream: flags stay live until the next edge, then drop.
    instruction = 32'h2010FEFE;
    reset       = 1'b1;
    #1;
    check("mid_rst_pre.reg_write", 32'(reg_write), 32'd1);
    @(posedge clk); #1;
    check("mid_rst.reg_write", 32'(reg_write), 32'd0);
    check("mid_rst.alu_src",   32'(alu_src),   32'(SRC_SEXT));
    instruction = 32'h1520FFFD;
    #1;
    check("mid_rst.is_branch", 32'(is_branch), 32'd0);
    $display("mid-stream reset: reg_write=%0b is_branch=%0b", reg_write, is_branch);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_release.is_branch", 32'(is_branch), 32'd1);
    $display("mid-stream release: is_branch=%0b", is_branch);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
